// File: rtl/mode_sequencer.sv
// Central mode controller for the clock/timer/stopwatch display: owns the display mode, mux select,
// colour/blank outputs, routes front-panel button edges as one-cycle command pulses to the active
// function, auto-repeats the timer add buttons and runs the timer-expiry alarm.
// Ports: clk/reset (sync, active-high); tick_khz enable strobe; select/toggle/add_one/add_ten buttons
// and timer_done (levels); mux_select, disp_blue, disp_blank, command pulses, alarm_active (all registered).
module mode_sequencer #(
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned BLINK_TICKS  = 250,
  parameter int unsigned ALARM_TICKS  = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_khz,
  input  logic       select_btn,
  input  logic       toggle_btn,
  input  logic       add_one_btn,
  input  logic       add_ten_btn,
  input  logic       timer_done,
  output logic [1:0] mux_select,
  output logic       disp_blue,
  output logic       disp_blank,
  output logic       sw_toggle,
  output logic       tmr_toggle,
  output logic       tmr_add_one,
  output logic       tmr_add_ten,
  output logic       alarm_active
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int AW = $clog2(ALARM_TICKS + 1);

  // Low two bits of the mode states equal the display mux code.
  typedef enum logic [2:0] {
    S_M12   = 3'd0,
    S_M24   = 3'd1,
    S_MSW   = 3'd2,
    S_MTMR  = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  state_t state_q, state_d;
  state_t saved_mode_q, saved_mode_d;

  // Bit order: 0 select, 1 toggle, 2 add_one, 3 add_ten, 4 timer_done
  logic [4:0] btn_in;
  logic [4:0] btn_edge;
  logic [4:0] btn_prev_q, btn_prev_d;

  logic [1:0][HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic [AW-1:0]      alarm_cnt_q, alarm_cnt_d;

  logic [1:0] mux_select_q, mux_select_d;
  logic       disp_blue_q, disp_blue_d;
  logic       disp_blank_q, disp_blank_d;
  logic       sw_toggle_q, sw_toggle_d;
  logic       tmr_toggle_q, tmr_toggle_d;
  logic       tmr_add_one_q, tmr_add_one_d;
  logic       tmr_add_ten_q, tmr_add_ten_d;
  logic       alarm_active_q, alarm_active_d;

  logic [1:0] add_btn;
  logic [1:0] add_edge_pulse;
  logic [1:0] add_rep_pulse;
  logic       ack_edge;
  logic       stay_tmr;

  assign btn_in     = {timer_done, add_ten_btn, add_one_btn, toggle_btn, select_btn};
  assign btn_edge   = btn_in & ~btn_prev_q;
  assign btn_prev_d = btn_in;
  assign add_btn    = {add_ten_btn, add_one_btn};
  // Any panel button edge acknowledges the alarm; timer_done does not.
  assign ack_edge   = |btn_edge[3:0];

  always_comb begin
    state_d        = state_q;
    saved_mode_d   = saved_mode_q;
    blink_cnt_d    = blink_cnt_q;
    alarm_cnt_d    = alarm_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    rep_cnt_d      = rep_cnt_q;
    disp_blank_d   = 1'b0;
    sw_toggle_d    = 1'b0;
    tmr_toggle_d   = 1'b0;
    add_edge_pulse = 2'b00;
    add_rep_pulse  = 2'b00;
    stay_tmr       = 1'b0;

    if (state_q == S_ALARM) begin
      disp_blank_d = disp_blank_q;
      // The acknowledging edge is swallowed here: no routing, no mode advance.
      if (ack_edge || (tick_khz && alarm_cnt_q == AW'(ALARM_TICKS - 1))) begin
        state_d      = saved_mode_q;
        disp_blank_d = 1'b0;
        blink_cnt_d  = '0;
        alarm_cnt_d  = '0;
      end else if (tick_khz) begin
        if (alarm_cnt_q != AW'(ALARM_TICKS)) begin
          alarm_cnt_d = alarm_cnt_q + 1'b1;
        end
        if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
          blink_cnt_d  = '0;
          disp_blank_d = ~disp_blank_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end else begin
      // Commands route on the pre-advance state, even when the mode changes this cycle.
      sw_toggle_d    = btn_edge[1] && (state_q == S_MSW);
      tmr_toggle_d   = btn_edge[1] && (state_q == S_MTMR);
      add_edge_pulse = (state_q == S_MTMR) ? btn_edge[3:2] : 2'b00;

      if (btn_edge[4]) begin
        // Timer expiry beats a coincident select; save the pre-edge mode.
        saved_mode_d = state_q;
        state_d      = S_ALARM;
        blink_cnt_d  = '0;
        alarm_cnt_d  = '0;
      end else if (btn_edge[0]) begin
        case (state_q)
          S_M12:   state_d = S_M24;
          S_M24:   state_d = S_MSW;
          S_MSW:   state_d = S_MTMR;
          default: state_d = S_M12;
        endcase
      end
    end

    // Hold/repeat counters only run while the timer mode is stable; any mode change clears them.
    stay_tmr = (state_q == S_MTMR) && (state_d == S_MTMR);
    for (int i = 0; i < 2; i++) begin
      if (!stay_tmr || !add_btn[i]) begin
        hold_cnt_d[i] = '0;
        rep_cnt_d[i]  = '0;
      end else if (tick_khz) begin
        if (hold_cnt_q[i] != HW'(HOLD_TICKS)) begin
          hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
          if (hold_cnt_q[i] == HW'(HOLD_TICKS - 1)) begin
            add_rep_pulse[i] = 1'b1;
          end
        end else if (rep_cnt_q[i] == RW'(REPEAT_TICKS - 1)) begin
          rep_cnt_d[i]     = '0;
          add_rep_pulse[i] = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end

    tmr_add_one_d  = add_edge_pulse[0] | add_rep_pulse[0];
    tmr_add_ten_d  = add_edge_pulse[1] | add_rep_pulse[1];
    mux_select_d   = (state_d == S_ALARM) ? 2'b11 : 2'(state_d);
    disp_blue_d    = (state_d == S_M24);
    alarm_active_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_M12;
      saved_mode_q   <= S_M12;
      btn_prev_q     <= '0;
      hold_cnt_q     <= '0;
      rep_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      alarm_cnt_q    <= '0;
      mux_select_q   <= 2'b00;
      disp_blue_q    <= 1'b0;
      disp_blank_q   <= 1'b0;
      sw_toggle_q    <= 1'b0;
      tmr_toggle_q   <= 1'b0;
      tmr_add_one_q  <= 1'b0;
      tmr_add_ten_q  <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      saved_mode_q   <= saved_mode_d;
      btn_prev_q     <= btn_prev_d;
      hold_cnt_q     <= hold_cnt_d;
      rep_cnt_q      <= rep_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      alarm_cnt_q    <= alarm_cnt_d;
      mux_select_q   <= mux_select_d;
      disp_blue_q    <= disp_blue_d;
      disp_blank_q   <= disp_blank_d;
      sw_toggle_q    <= sw_toggle_d;
      tmr_toggle_q   <= tmr_toggle_d;
      tmr_add_one_q  <= tmr_add_one_d;
      tmr_add_ten_q  <= tmr_add_ten_d;
      alarm_active_q <= alarm_active_d;
    end
  end

  assign mux_select   = mux_select_q;
  assign disp_blue    = disp_blue_q;
  assign disp_blank   = disp_blank_q;
  assign sw_toggle    = sw_toggle_q;
  assign tmr_toggle   = tmr_toggle_q;
  assign tmr_add_one  = tmr_add_one_q;
  assign tmr_add_ten  = tmr_add_ten_q;
  assign alarm_active = alarm_active_q;

endmodule
